// File: rtl/aperture_lookup.sv
// Aperture lookup engine: scans 16-byte descriptors in a shared 512x8 cfg RAM
// to translate a host page index into an SDRAM byte address. The host port always wins the RAM.
module aperture_lookup #(
  parameter int NUM_DESC = 16
) (
  input  logic        clk200,
  input  logic        rst_n,
  input  logic        host_en,
  input  logic        host_we,
  input  logic [8:0]  host_addr,
  input  logic [7:0]  host_wdata,
  output logic [7:0]  host_rdata,
  output logic [8:0]  ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  input  logic        lookup_req,
  input  logic [7:0]  lookup_page,
  output logic        lookup_busy,
  output logic        lookup_done,
  output logic        lookup_hit,
  output logic [3:0]  lookup_idx,
  output logic [31:0] lookup_sdram
);

  typedef enum logic [2:0] {IDLE, RD_START, RD_COUNT, CHECK, RD_BASE, DONE} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_DESC - 1);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [2:0]  k_q, k_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  start_q, start_d;
  logic [31:0] base_q, base_d;
  logic        hit_pend_q, hit_pend_d;
  logic        cap_vld_q, cap_vld_d;
  logic [2:0]  cap_sel_q, cap_sel_d;
  logic        done_q, done_d;
  logic        hit_q, hit_d;
  logic [3:0]  idx_out_q, idx_out_d;
  logic [31:0] sdram_q, sdram_d;

  logic [8:0]  fsm_addr;
  logic        issue;
  logic        match;
  logic [7:0]  offset;

  // Count bypasses the capture path: it is on ram_rdata during CHECK.
  assign offset = page_q - start_q;
  assign match  = (ram_rdata != 8'h00) && (page_q >= start_q) && (offset < ram_rdata);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    k_d        = k_q;
    page_d     = page_q;
    hit_pend_d = hit_pend_q;
    fsm_addr   = 9'h000;
    issue      = 1'b0;
    cap_vld_d  = 1'b0;
    cap_sel_d  = 3'd0;
    done_d     = 1'b0;
    hit_d      = hit_q;
    idx_out_d  = idx_out_q;
    sdram_d    = sdram_q;

    case (state_q)
      IDLE: begin
        if (lookup_req) begin
          page_d  = lookup_page;
          idx_d   = 4'd0;
          state_d = RD_START;
        end
      end
      RD_START: begin
        fsm_addr  = {1'b0, idx_q, 4'h4};
        issue     = !host_en;
        cap_vld_d = issue;
        cap_sel_d = 3'd0;
        if (issue) state_d = RD_COUNT;
      end
      RD_COUNT: begin
        fsm_addr = {1'b0, idx_q, 4'h5};
        issue    = !host_en;
        if (issue) state_d = CHECK;
      end
      CHECK: begin
        hit_pend_d = match;
        if (match) begin
          k_d     = 3'd0;
          state_d = RD_BASE;
        end else if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = RD_START;
        end
      end
      RD_BASE: begin
        // k==4 is a wait slot for the last byte's capture; no read issued.
        if (k_q[2]) begin
          state_d = DONE;
        end else begin
          fsm_addr  = {1'b0, idx_q, 2'b00, k_q[1:0]};
          issue     = !host_en;
          cap_vld_d = issue;
          cap_sel_d = {1'b1, k_q[1:0]};
          if (issue) k_d = k_q + 3'd1;
        end
      end
      DONE: begin
        done_d    = 1'b1;
        hit_d     = hit_pend_q;
        idx_out_d = hit_pend_q ? idx_q : 4'd0;
        sdram_d   = hit_pend_q ? (base_q + {16'h0000, offset, 8'h00}) : 32'h0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start_d = start_q;
    base_d  = base_q;
    if (cap_vld_q) begin
      if (cap_sel_q[2]) base_d[8*cap_sel_q[1:0] +: 8] = ram_rdata;
      else              start_d = ram_rdata;
    end
  end

  always_ff @(posedge clk200 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= 4'd0;
      k_q        <= 3'd0;
      page_q     <= 8'h00;
      start_q    <= 8'h00;
      base_q     <= 32'h0;
      hit_pend_q <= 1'b0;
      cap_vld_q  <= 1'b0;
      cap_sel_q  <= 3'd0;
      done_q     <= 1'b0;
      hit_q      <= 1'b0;
      idx_out_q  <= 4'd0;
      sdram_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      k_q        <= k_d;
      page_q     <= page_d;
      start_q    <= start_d;
      base_q     <= base_d;
      hit_pend_q <= hit_pend_d;
      cap_vld_q  <= cap_vld_d;
      cap_sel_q  <= cap_sel_d;
      done_q     <= done_d;
      hit_q      <= hit_d;
      idx_out_q  <= idx_out_d;
      sdram_q    <= sdram_d;
    end
  end

  assign ram_addr     = host_en ? host_addr : fsm_addr;
  assign ram_we       = host_en & host_we;
  assign ram_wdata    = host_en ? host_wdata : 8'h00;
  assign host_rdata   = ram_rdata;
  assign lookup_busy  = (state_q != IDLE);
  assign lookup_done  = done_q;
  assign lookup_hit   = hit_q;
  assign lookup_idx   = idx_out_q;
  assign lookup_sdram = sdram_q;

endmodule

// File: tb/tb_aperture_lookup.sv
// Directed bench for aperture_lookup: a descriptor-scan model predicts result and
// latency, and a per-cycle compare process checks busy/done/result against it.
module tb_aperture_lookup;

  localparam int NUM_DESC = 16;

  logic        clk200 = 1'b0;
  logic        rst_n;
  logic        host_en, host_we;
  logic [8:0]  host_addr;
  logic [7:0]  host_wdata, host_rdata;
  logic [8:0]  ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata, ram_rdata;
  logic        lookup_req;
  logic [7:0]  lookup_page;
  logic        lookup_busy, lookup_done, lookup_hit;
  logic [3:0]  lookup_idx;
  logic [31:0] lookup_sdram;

  always #5 clk200 = ~clk200;

  aperture_lookup #(.NUM_DESC(NUM_DESC)) dut (
    .clk200(clk200), .rst_n(rst_n),
    .host_en(host_en), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .lookup_req(lookup_req), .lookup_page(lookup_page),
    .lookup_busy(lookup_busy), .lookup_done(lookup_done), .lookup_hit(lookup_hit),
    .lookup_idx(lookup_idx), .lookup_sdram(lookup_sdram)
  );

  // 512x8 cfg RAM with registered read
  logic [7:0] mem [0:511];
  always @(posedge clk200) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk200) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Expected result of the lookup in flight
  bit          armed = 1'b0;
  int          req_cyc, exp_lat, cmp_k;
  logic        exp_hit;
  logic [3:0]  exp_idx;
  logic [31:0] exp_sdram;

  always @(negedge clk200) begin
    if (armed) begin
      cmp_k = cyc - req_cyc;
      chk("busy", 32'(lookup_busy), 32'(cmp_k < exp_lat));
      chk("done", 32'(lookup_done), 32'(cmp_k == exp_lat));
      if (cmp_k >= exp_lat) begin
        chk("hit", 32'(lookup_hit), 32'(exp_hit));
        chk("idx", 32'(lookup_idx), 32'(exp_idx));
        chk("sdram", lookup_sdram, exp_sdram);
      end
    end
  end

  task automatic model(input logic [7:0] p, output logic h, output logic [3:0] ix,
                       output logic [31:0] sd, output int lat);
    h = 1'b0; ix = 4'd0; sd = 32'h0; lat = 3 * NUM_DESC + 1;
    for (int d = 0; d < NUM_DESC; d++) begin
      int s, c;
      s = int'(mem[16*d+4]);
      c = int'(mem[16*d+5]);
      if (!h && c != 0 && int'(p) >= s && (int'(p) - s) < c) begin
        h   = 1'b1;
        ix  = 4'(d);
        sd  = {mem[16*d+3], mem[16*d+2], mem[16*d+1], mem[16*d]} + 32'((int'(p) - s) * 256);
        lat = 3 * d + 9;
      end
    end
  endtask

  task automatic host_write(input logic [8:0] a, input logic [7:0] d);
    host_en = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
    @(posedge clk200); #1;
    host_en = 1'b0; host_we = 1'b0;
  endtask

  task automatic host_read_chk(input string name, input logic [8:0] a, input logic [7:0] exp);
    host_en = 1'b1; host_we = 1'b0; host_addr = a;
    @(posedge clk200); #1;
    host_en = 1'b0;
    chk(name, 32'(host_rdata), 32'(exp));
  endtask

  task automatic set_desc(input int d, input logic [7:0] s, input logic [7:0] c, input logic [31:0] b);
    for (int i = 0; i < 4; i++) host_write(9'(16*d + i), b[8*i +: 8]);
    host_write(9'(16*d + 4), s);
    host_write(9'(16*d + 5), c);
  endtask

  // hmask bit c puts a host write in the cycle after request edge c.
  task automatic run_lookup(input logic [7:0] p, input int extra, input logic [15:0] hmask,
                            input bit hold_req, input logic lh, input logic [3:0] li,
                            input logic [31:0] ls, input int ll);
    logic h; logic [3:0] ix; logic [31:0] sd; int lat;
    armed = 1'b0;
    model(p, h, ix, sd, lat);
    lat = lat + extra;
    chk("model_hit", 32'(h), 32'(lh));
    chk("model_idx", 32'(ix), 32'(li));
    chk("model_sdram", sd, ls);
    chk("model_lat", 32'(lat), 32'(ll));
    exp_hit = h; exp_idx = ix; exp_sdram = sd; exp_lat = lat;
    lookup_req = 1'b1; lookup_page = p;
    @(posedge clk200); #1;
    req_cyc = cyc;
    armed = 1'b1;
    for (int c = 0; c <= lat + 2; c++) begin
      lookup_req  = hold_req && (c < lat - 2);
      lookup_page = hold_req ? 8'h00 : p;
      host_en     = (c < 16) && hmask[c];
      host_we     = 1'b1;
      host_addr   = 9'(9'h100 + c);
      host_wdata  = 8'(8'hA0 + c);
      @(posedge clk200); #1;
    end
    host_en = 1'b0; host_we = 1'b0; lookup_req = 1'b0;
  endtask

  initial begin
    int dones;
    rst_n = 1'b0; host_en = 1'b0; host_we = 1'b0; host_addr = 9'h0; host_wdata = 8'h0;
    lookup_req = 1'b0; lookup_page = 8'h0;
    repeat (3) @(posedge clk200);
    #1;
    chk("rst_busy", 32'(lookup_busy), 0);
    chk("rst_done", 32'(lookup_done), 0);
    chk("rst_hit", 32'(lookup_hit), 0);
    chk("rst_idx", 32'(lookup_idx), 0);
    chk("rst_sdram", lookup_sdram, 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    host_en = 1'b1; host_we = 1'b1; host_addr = 9'h1FF; host_wdata = 8'h5A;
    #1;
    chk("host_prio_we", 32'(ram_we), 1);
    chk("host_prio_addr", 32'(ram_addr), 32'h1FF);
    chk("host_prio_wdata", 32'(ram_wdata), 32'h5A);
    host_en = 1'b0; host_we = 1'b0;
    #1;
    chk("host_idle_we", 32'(ram_we), 0);
    @(posedge clk200); #1;
    rst_n = 1'b1;
    @(posedge clk200); #1;

    for (int a = 0; a < 512; a++) host_write(9'(a), 8'h00);

    // every descriptor empty: full miss
    run_lookup(8'h10, 0, 16'h0, 1'b0, 1'b0, 4'd0, 32'h0, 49);

    set_desc(0, 8'h40, 8'h10, 32'h0010_0000);
    host_read_chk("rd_desc0_start", 9'h004, 8'h40);
    run_lookup(8'h45, 0, 16'h0, 1'b0, 1'b1, 4'd0, 32'h0010_0500, 9);
    run_lookup(8'h4F, 0, 16'h0, 1'b0, 1'b1, 4'd0, 32'h0010_0F00, 9);
    run_lookup(8'h3F, 0, 16'h0, 1'b0, 1'b0, 4'd0, 32'h0, 49);
    run_lookup(8'h50, 0, 16'h0, 1'b0, 1'b0, 4'd0, 32'h0, 49);

    // host traffic on three issue slots
    run_lookup(8'h45, 3, 16'h0091, 1'b0, 1'b1, 4'd0, 32'h0010_0500, 12);
    host_read_chk("host_wr_100", 9'h100, 8'hA0);
    host_read_chk("host_wr_104", 9'h104, 8'hA4);
    host_read_chk("host_wr_107", 9'h107, 8'hA7);
    host_read_chk("host_wr_101", 9'h101, 8'h00);

    set_desc(3, 8'hF8, 8'h10, 32'h1234_5678);
    host_read_chk("rd_desc3_start", 9'h034, 8'hF8);
    run_lookup(8'hFF, 0, 16'h0, 1'b0, 1'b1, 4'd3, 32'h1234_5D78, 18);
    run_lookup(8'h07, 0, 16'h0, 1'b0, 1'b0, 4'd0, 32'h0, 49);
    run_lookup(8'hF8, 0, 16'h0, 1'b0, 1'b1, 4'd3, 32'h1234_5678, 18);

    set_desc(2, 8'h60, 8'h04, 32'hAABB_0000);
    set_desc(5, 8'h50, 8'h20, 32'h0100_0000);
    run_lookup(8'h62, 0, 16'h0, 1'b1, 1'b1, 4'd2, 32'hAABB_0200, 15);
    run_lookup(8'h6F, 0, 16'h0, 1'b0, 1'b1, 4'd5, 32'h0100_1F00, 24);

    // reset pulse while fetching base bytes
    armed = 1'b0;
    lookup_req = 1'b1; lookup_page = 8'h45;
    @(posedge clk200); #1;
    lookup_req = 1'b0;
    repeat (4) @(posedge clk200);
    #1;
    chk("pre_rst_busy", 32'(lookup_busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(lookup_busy), 0);
    chk("mid_rst_hit", 32'(lookup_hit), 0);
    chk("mid_rst_idx", 32'(lookup_idx), 0);
    chk("mid_rst_sdram", lookup_sdram, 0);
    @(posedge clk200); #1;
    rst_n = 1'b1;
    dones = 0;
    repeat (12) begin
      @(posedge clk200); #1;
      if (lookup_done) dones++;
    end
    chk("no_done_after_rst", 32'(dones), 0);
    chk("idle_after_rst", 32'(lookup_busy), 0);
    run_lookup(8'h45, 0, 16'h0, 1'b0, 1'b1, 4'd0, 32'h0010_0500, 9);
    armed = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/aperture_lookup.md
APERTURE_LOOKUP -- requirements
Module: aperture_lookup

Interface
REQ-001 SHALL have parameter NUM_DESC, default 16, giving the number of 16-byte descriptors scanned (1..16) from cfg address 0x000.
REQ-002 SHALL have the clock and reset ports first: clk200 input 1 (single clock, all logic on posedge); rst_n input 1 (reset is asynchronous and active-low).
REQ-003 SHALL have host_en input 1, host access this cycle.
REQ-004 SHALL have host_we input 1, host write qualifier.
REQ-005 SHALL have host_addr input 9, host cfg address.
REQ-006 SHALL have host_wdata input 8, host write data.
REQ-007 SHALL have host_rdata output 8, equal to ram_rdata, valid the cycle after a host_en read.
REQ-008 SHALL have ram_addr output 9, ram_we output 1, ram_wdata output 8 and ram_rdata input 8, forming the port to the 512x8 cfg RAM (1-cycle registered read).
REQ-009 SHALL have lookup_req input 1, start lookup.
REQ-010 SHALL have lookup_page input 8, host page index to resolve.
REQ-011 SHALL have lookup_busy output 1, lookup in progress.
REQ-012 SHALL have lookup_done output 1, a one-cycle completion pulse.
REQ-013 SHALL have lookup_hit output 1, valid with done, 1 = aperture matched.
REQ-014 SHALL have lookup_idx output 4, matching descriptor index, valid with done when hit.
REQ-015 SHALL have lookup_sdram output 32, resolved SDRAM byte address, valid with done when hit.

Function
REQ-016 SHALL give the host absolute priority: when host_en=1, ram_addr=host_addr, ram_we=host_we, ram_wdata=host_wdata combinationally; otherwise ram_we=0 and ram_addr=the FSM address.
REQ-017 SHALL use FSM states IDLE, RD_START, RD_COUNT, CHECK, RD_BASE, DONE.
REQ-018 SHALL, in IDLE, accept lookup_req=1, latch lookup_page, clear idx to 0, go to RD_START, and assert lookup_busy from the next cycle until DONE inclusive.
REQ-019 SHALL ignore lookup_req in any state other than IDLE.
REQ-020 SHALL, in RD_START, issue address {1'b0, idx, 4'h4}; in RD_COUNT, issue {1'b0, idx, 4'h5}; in RD_BASE, issue {1'b0, idx, 2'b00, k} for k=0..3.
REQ-021 SHALL count a read as issued only in a cycle with host_en=0; when host_en=1 the FSM holds its state and address-sequence position and reissues the read in the next free cycle.
REQ-022 SHALL load the capture register for an issued read from ram_rdata in exactly the cycle after issue, regardless of host_en in that cycle.
REQ-023 SHALL, in CHECK, declare a hit iff count!=0, page>=start and (page-start)<count, using 8-bit unsigned compare with no wrap past 0xFF.
REQ-024 SHALL, in CHECK, on a hit go to RD_BASE; on a miss with idx==NUM_DESC-1 go to DONE with hit=0; otherwise increment idx and go to RD_START.
REQ-025 SHALL assemble base as little-endian bytes 0..3 and compute lookup_sdram = base + ((page-start)<<8), modulo 2^32.
REQ-026 SHALL, in RD_BASE, go to DONE after all four bytes are captured.
REQ-027 SHALL, in DONE, pulse lookup_done for one cycle, drive hit/idx/sdram, then return to IDLE.
REQ-028 SHALL hold lookup_hit/idx/sdram until the next accepted lookup, and report idx=0 and sdram=0 on a miss.
REQ-029 SHALL meet latency with no host contention: done asserted 9 cycles after the request edge for a hit on descriptor 0; 3*n+9 cycles for a first hit at descriptor n; 3*NUM_DESC+1 cycles for a full miss; each host_en cycle landing on an issue slot adds one cycle.
REQ-030 SHALL report the lowest-index matching descriptor when several descriptors match.
REQ-031 SHALL compute results from bytes as captured at their read time when host writes to descriptors occur mid-lookup; no retry is performed.

Reset
REQ-032 SHALL, while rst_n=0, force state to IDLE and set lookup_busy, lookup_done, lookup_hit, lookup_idx and lookup_sdram to 0, along with all capture registers; ram_we SHALL be 0 unless host_en=1.
REQ-033 SHALL, on reset asserted mid-lookup, abort the lookup with no done pulse; the first request after rst_n rises SHALL be accepted normally.

Verification
REQ-034 SHALL pass this scenario: desc0 start=0x40, count=0x10, base=0x00100000; lookup page 0x45 -> done at cycle 9, hit=1, idx=0, sdram=0x00100500.
REQ-035 SHALL pass this scenario: all descriptors count=0; lookup 0x10 -> done at cycle 49, hit=0, sdram=0.
REQ-036 SHALL pass this scenario: desc3 start=0xF8, count=0x10; lookup 0xFF -> hit idx=3, offset 0x700; lookup 0x07 -> miss.
REQ-037 SHALL pass this scenario: desc0 hit setup plus host_en=1 on 3 issue cycles during the lookup -> done at cycle 12, same result; host writes land in RAM.
REQ-038 SHALL pass this scenario: desc2 and desc5 both match -> idx=2.
REQ-039 SHALL pass this scenario: rst_n pulsed low in RD_BASE -> busy=0, no done; a new request completes correctly.
